// File: rtl/cnt_timer_pkg.sv
// Shared types and constants for the counter-chain timer sequencer.
package cnt_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_RELOAD   = 2'd0;
  localparam logic [1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [1:0] ADDR_CONTROL  = 2'd2;

  localparam int CTRL_START    = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQEN    = 2;
  localparam int CTRL_STOP     = 3;

endpackage

// File: rtl/cnt_prescaler.sv
// Prescaler: counts while enabled, ticks and wraps when it reaches term.
// tick is combinational from the registered count, so it is valid in the same cycle.
module cnt_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PRE_W-1:0] term,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  assign tick = en && (cnt == term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/ctnr_timer_ctrl.sv
// Timer sequencer driving a loadable toggle-cell up-counter chain: load, count enable, TC irq.
// Optional CNTR_TIMER_GATE_EN adds a gate input that suspends counting while low in RUN.
module ctnr_timer_ctrl
  import cnt_timer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PRE_W = 8
) (
  input  logic             CK,
  input  logic             RESET,
`ifdef CNTR_TIMER_GATE_EN
  input  logic             gate,
`endif
  input  logic             wr,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             irq_ack,
  input  logic [WIDTH-1:0] cnt_q,
  output logic [WIDTH-1:0] ld_d,
  output logic             ld,
  output logic             ldl,
  output logic             enab,
  output logic             running,
  output logic             irq
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] reload_r;
  logic [PRE_W-1:0] prescale_r;
  logic             periodic_r;
  logic             irqen_r;
  logic             ctrl_wr;
  logic             start;
  logic             stop;
  logic             gate_ok;
  logic             count_en;
  logic             tick;
  logic             tc;

`ifdef CNTR_TIMER_GATE_EN
  assign gate_ok = gate;
`else
  assign gate_ok = 1'b1;
`endif

  assign ctrl_wr  = wr && (addr == ADDR_CONTROL);
  assign start    = ctrl_wr && wdata[CTRL_START];
  assign stop     = ctrl_wr && wdata[CTRL_STOP];
  assign count_en = (state == RUN) && gate_ok;
  assign tc       = tick && (&cnt_q);

  always_ff @(posedge CK or posedge RESET) begin
    if (RESET) begin
      reload_r   <= '0;
      prescale_r <= '0;
      periodic_r <= 1'b0;
      irqen_r    <= 1'b0;
    end else if (wr) begin
      case (addr)
        ADDR_RELOAD:   reload_r   <= wdata;
        ADDR_PRESCALE: prescale_r <= wdata[PRE_W-1:0];
        ADDR_CONTROL: begin
          periodic_r <= wdata[CTRL_PERIODIC];
          irqen_r    <= wdata[CTRL_IRQEN];
        end
        default: ;
      endcase
    end
  end

  // Outside RUN the prescaler is held at zero, which covers the clear in LOAD.
  cnt_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk  (CK),
    .rst  (RESET),
    .clr  (state != RUN),
    .en   (count_en),
    .term (prescale_r),
    .tick (tick)
  );

  always_ff @(posedge CK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      LOAD:    state_nxt = RUN;
      RUN:     if (tc) state_nxt = periodic_r ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (stop) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = LOAD;
    end
  end

  always_comb begin
    ld      = (state == LOAD);
    ldl     = ~ld;
    enab    = tick;
    running = (state != IDLE);
    ld_d    = reload_r;
  end

  // A TC in the same cycle as an ack keeps the interrupt asserted.
  always_ff @(posedge CK or posedge RESET) begin
    if (RESET) begin
      irq <= 1'b0;
    end else if (tc && irqen_r) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ctnr_timer_ctrl.sv
// Directed bench for ctnr_timer_ctrl with a behavioural toggle-cell chain on cnt_q.
// Latency: checks sampled 1 time unit after each rising edge of CK.
// Backpressure: none; the bench drives register writes and irq_ack directly.
module tb_ctnr_timer_ctrl;
    import cnt_timer_pkg::*;

    localparam int W = 16;

    logic         CK;
    logic         RESET;
    logic         gate;
    logic         wr;
    logic [1:0]   addr;
    logic [W-1:0] wdata;
    logic         irq_ack;
    logic [W-1:0] cnt_q;
    logic [W-1:0] ld_d;
    logic         ld;
    logic         ldl;
    logic         enab;
    logic         running;
    logic         irq;

    int total = 0;
    int bad   = 0;
    int ld_cnt = 0;
    int enab_cnt = 0;
    bit overlap = 1'b0;

    ctnr_timer_ctrl #(.WIDTH(W), .PRE_W(8)) dut (
        .CK      (CK),
        .RESET   (RESET),
`ifdef CNTR_TIMER_GATE_EN
        .gate    (gate),
`endif
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .irq_ack (irq_ack),
        .cnt_q   (cnt_q),
        .ld_d    (ld_d),
        .ld      (ld),
        .ldl     (ldl),
        .enab    (enab),
        .running (running),
        .irq     (irq)
    );

    logic [W:0] carry;
    assign carry[0] = enab;
    for (genvar i = 0; i < W; i++) begin : g_cell
        logic q_b = 1'b0;
        logic x_b;
        logic ao_b;
        assign x_b        = q_b ^ carry[i];
        assign ao_b       = (ld_d[i] & ld) | (x_b & ldl);
        assign carry[i+1] = carry[i] & q_b;
        assign cnt_q[i]   = q_b;
        always @(posedge CK) q_b <= ao_b;
    end

    initial CK = 1'b0;
    always #5 CK = ~CK;

    always @(negedge CK) begin
        if (ld) ld_cnt++;
        if (enab) enab_cnt++;
        if (ld && enab) overlap = 1'b1;
    end

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [W-1:0] d);
        wr = 1'b1; addr = a; wdata = d;
        step();
        wr = 1'b0; addr = 2'd3; wdata = '0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; wr = 1'b0; addr = 2'd3; wdata = '0; irq_ack = 1'b0; gate = 1'b1;
        step(); step();
        total++; if (ld !== 1'b0) begin bad++; $display("FAIL reset_ld got=%b want=0", ld); end
        total++; if (ldl !== 1'b1) begin bad++; $display("FAIL reset_ldl got=%b want=1", ldl); end
        total++; if (enab !== 1'b0) begin bad++; $display("FAIL reset_enab got=%b want=0", enab); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", running); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
        total++; if (ld_d !== 16'h0000) begin bad++; $display("FAIL reset_ld_d got=%h want=0000", ld_d); end
        RESET = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_run();
        wr_reg(ADDR_RELOAD, 16'hFFF0);
        wr_reg(ADDR_PRESCALE, 16'h0003);
        wr_reg(ADDR_CONTROL, 16'h0001);
        for (int k = 0; k < 8; k++) step();
        total++; if (enab !== 1'b1) begin bad++; $display("FAIL midrun_enab_before got=%b want=1", enab); end
        RESET = 1'b1;
        #1;
        total++; if (enab !== 1'b0) begin bad++; $display("FAIL midrun_enab_async got=%b want=0", enab); end
        total++; if (ld !== 1'b0 || ldl !== 1'b1) begin bad++; $display("FAIL midrun_ld_async got=%b/%b want=0/1", ld, ldl); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL midrun_running got=%b want=0", running); end
        total++; if (ld_d !== 16'h0000) begin bad++; $display("FAIL midrun_ld_d got=%h want=0000", ld_d); end
        step(); step();
        RESET = 1'b0;
        ld_cnt = 0; enab_cnt = 0;
        for (int k = 0; k < 30; k++) step();
        total++; if (ld_cnt != 0 || enab_cnt != 0) begin
            bad++;
            $display("FAIL midrun_quiet got ld=%0d enab=%0d want 0/0", ld_cnt, enab_cnt);
        end
    endtask

    task automatic test_one_shot();
        wr_reg(ADDR_RELOAD, 16'hFFFC);
        wr_reg(ADDR_PRESCALE, 16'h0000);
        ld_cnt = 0; enab_cnt = 0;
        wr_reg(ADDR_CONTROL, 16'h0005);
        total++; if (ld !== 1'b1) begin bad++; $display("FAIL oneshot_ld got=%b want=1", ld); end
        for (int k = 1; k <= 4; k++) begin
            step();
            total++; if (enab !== 1'b1) begin bad++; $display("FAIL oneshot_enab%0d got=%b want=1", k, enab); end
        end
        total++; if (cnt_q !== 16'hFFFF || irq !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_tc_cycle got cnt=%h irq=%b want FFFF/0", cnt_q, irq);
        end
        step();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL oneshot_irq got=%b want=1", irq); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL oneshot_running got=%b want=0", running); end
        total++; if (cnt_q !== 16'h0000) begin bad++; $display("FAIL oneshot_cnt got=%h want=0000", cnt_q); end
        total++; if (ld_cnt != 1 || enab_cnt != 4) begin
            bad++;
            $display("FAIL oneshot_pulses got ld=%0d enab=%0d want 1/4", ld_cnt, enab_cnt);
        end
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_ack got=%b want=0", irq); end
    endtask

    task automatic test_periodic();
        logic [W-1:0] exp_cnt;
        logic exp_ld;
        logic exp_en;
        int m;
        wr_reg(ADDR_RELOAD, 16'hFFFE);
        wr_reg(ADDR_PRESCALE, 16'h0002);
        wr_reg(ADDR_CONTROL, 16'h0003);
        for (int k = 1; k <= 21; k++) begin
            step();
            m = k % 7;
            exp_cnt = (m == 0) ? 16'h0000 : (m <= 3) ? 16'hFFFE : 16'hFFFF;
            exp_ld  = (m == 0);
            exp_en  = (m == 3) || (m == 6);
            total++; if (cnt_q !== exp_cnt) begin bad++; $display("FAIL periodic_cnt k=%0d got=%h want=%h", k, cnt_q, exp_cnt); end
            total++; if (ld !== exp_ld) begin bad++; $display("FAIL periodic_ld k=%0d got=%b want=%b", k, ld, exp_ld); end
            total++; if (enab !== exp_en) begin bad++; $display("FAIL periodic_enab k=%0d got=%b want=%b", k, enab, exp_en); end
        end
        wr_reg(ADDR_CONTROL, 16'h0008);
        total++; if (running !== 1'b0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL periodic_stop got run=%b irq=%b want 0/0", running, irq);
        end
    endtask

    task automatic test_stop_tc();
        wr_reg(ADDR_RELOAD, 16'hFFFF);
        wr_reg(ADDR_PRESCALE, 16'h0001);
        wr_reg(ADDR_CONTROL, 16'h0007);
        step(); step();
        total++; if (enab !== 1'b1 || cnt_q !== 16'hFFFF) begin
            bad++;
            $display("FAIL stoptc_pending got enab=%b cnt=%h want 1/FFFF", enab, cnt_q);
        end
        ld_cnt = 0;
        wr_reg(ADDR_CONTROL, 16'h000E);
        total++; if (running !== 1'b0) begin bad++; $display("FAIL stoptc_running got=%b want=0", running); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL stoptc_irq got=%b want=1", irq); end
        step(); step(); step();
        total++; if (ld_cnt != 0 || cnt_q !== 16'h0000) begin
            bad++;
            $display("FAIL stoptc_noload got ld=%0d cnt=%h want 0/0000", ld_cnt, cnt_q);
        end
    endtask

    task automatic test_ack_tc();
        wr_reg(ADDR_RELOAD, 16'hFFFF);
        wr_reg(ADDR_PRESCALE, 16'h0000);
        wr_reg(ADDR_CONTROL, 16'h0005);
        step();
        total++; if (enab !== 1'b1 || cnt_q !== 16'hFFFF) begin
            bad++;
            $display("FAIL acktc_tc got enab=%b cnt=%h want 1/FFFF", enab, cnt_q);
        end
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL acktc_setwins got=%b want=1", irq); end
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL acktc_clear got=%b want=0", irq); end
    endtask

`ifdef CNTR_TIMER_GATE_EN
    task automatic test_gate();
        int tc_at;
        tc_at = -1;
        gate = 1'b1;
        wr_reg(ADDR_RELOAD, 16'hFFFE);
        wr_reg(ADDR_PRESCALE, 16'h0001);
        wr_reg(ADDR_CONTROL, 16'h0001);
        step();
        gate = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++; if (enab !== 1'b0) begin bad++; $display("FAIL gate_enab%0d got=%b want=0", k, enab); end
            step();
        end
        gate = 1'b1;
        total++; if (cnt_q !== 16'hFFFE || running !== 1'b1) begin
            bad++;
            $display("FAIL gate_frozen got cnt=%h run=%b want FFFE/1", cnt_q, running);
        end
        for (int s = 6; s < 26; s++) begin
            if (enab === 1'b1 && cnt_q === 16'hFFFF) begin
                tc_at = s;
                break;
            end
            step();
        end
        total++; if (tc_at != 9) begin bad++; $display("FAIL gate_tc_cycle got=%0d want=9", tc_at); end
        step();
        total++; if (running !== 1'b0) begin bad++; $display("FAIL gate_done got=%b want=0", running); end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_run();
        test_one_shot();
        test_periodic();
        test_stop_tc();
        test_ack_tc();
`ifdef CNTR_TIMER_GATE_EN
        test_gate();
`endif
        total++; if (overlap) begin bad++; $display("FAIL ld_enab_overlap got=1 want=0"); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctnr_timer_ctrl.md
# ctnr_timer_ctrl

Sequencer for a WIDTH-bit loadable up-counter chain built from toggle counter cells (per-bit `D`, `LD`, `LDL`, `ENAB`, `CK`). It holds host-programmed reload and prescale values, drives the chain's load and count-enable strobes, detects terminal count, and raises a sticky interrupt. Each timer channel in the peripheral block uses one instance.

## Interface
Parameters:
- `WIDTH`, 16: counter chain width.
- `PRE_W`, 8: prescaler width.

Ports:
- `CK` in 1: system clock. All state changes on the rising edge.
- `RESET` in 1: **asynchronous, active-high** reset.
- `wr` in 1: host register write strobe, one cycle.
- `addr` in 2: register select. 0 = RELOAD, 1 = PRESCALE, 2 = CONTROL, 3 = unused (write ignored).
- `wdata` in WIDTH: write data. PRESCALE uses `[PRE_W-1:0]`. CONTROL uses bit0 START, bit1 PERIODIC, bit2 IRQEN, bit3 STOP.
- `irq_ack` in 1: clears `irq`.
- `cnt_q` in WIDTH: current counter chain value (cell `Q` outputs).
- `ld_d` out WIDTH: chain parallel-load data. Always equals RELOAD.
- `ld` out 1: chain load strobe.
- `ldl` out 1: chain hold. Always the inverse of `ld`.
- `enab` out 1: count enable for bit 0 of the chain. Upper bits carry internally.
- `running` out 1: high in LOAD or RUN.
- `irq` out 1: sticky terminal-count interrupt.

## Operation
- Registers RELOAD, PRESCALE, PERIODIC and IRQEN are written whenever `wr` is high. New values take effect at the next load or tick.
- FSM states:
  - IDLE: `ld` = 0, `enab` = 0. A START write moves to LOAD.
  - LOAD: one cycle. `ld` = 1 and `ldl` = 0, so the chain captures RELOAD on this edge. The prescaler clears to 0. Next state is RUN.
  - RUN: the prescaler increments each cycle. `tick` = (prescaler == PRESCALE), and the prescaler wraps to 0 on `tick`. `enab` = `tick`, combinational from registered state.
    - Terminal count (TC) = `tick` and `cnt_q` all ones. The chain wraps to 0 on this same edge.
    - On TC, `irq` is set if IRQEN = 1.
    - On TC with PERIODIC = 1, go to LOAD. With PERIODIC = 0, go to IDLE.
- A STOP write in any state goes to IDLE. STOP wins over START in the same write.
- A START write while in RUN restarts via LOAD.
- `irq` stays set until `irq_ack`. If set and `irq_ack` occur in the same cycle, set wins.
- PRESCALE = 0 gives a tick on every RUN cycle.
- RELOAD = all ones gives TC on the first tick.

## Timing
- Reset values: FSM IDLE, RELOAD = 0, PRESCALE = 0, PERIODIC = 0, IRQEN = 0, prescaler = 0, `ld` = 0, `ldl` = 1, `enab` = 0, `running` = 0, `irq` = 0, `ld_d` = 0.
- START write at edge N:
  - LOAD during cycle N+1, with `ld` high for exactly one cycle.
  - `cnt_q` = RELOAD after edge N+1 (chain loads on that edge).
  - First `enab` in cycle N+2+PRESCALE.
- Period in one-shot mode: TC occurs (2^WIDTH − RELOAD)·(PRESCALE+1) cycles after LOAD exits. `irq` goes high the edge after TC.
- Periodic mode: the LOAD cycle sits between TC and the next count, so the period is (2^WIDTH − RELOAD)·(PRESCALE+1) + 1 cycles.
- STOP or RESET during LOAD or RUN:
  - `ld` and `enab` deassert immediately (`ld` and `enab` deassert asynchronously with RESET).
  - A TC on the same edge as a STOP still sets `irq`.
- `ld` and `enab` are never high in the same cycle.

## Configuration
- `CNTR_TIMER_GATE_EN` defined: adds input port `gate` (1 bit).
  - While `gate` = 0 in RUN, the prescaler holds and `enab` = 0.
  - The FSM stays in RUN, and LOAD is unaffected.
- Macro undefined: no `gate` port, and counting is never suspended.

## Structure
- Package `cnt_timer_pkg`:
  - FSM state enum (IDLE, LOAD, RUN).
  - Address constants `ADDR_RELOAD`, `ADDR_PRESCALE`, `ADDR_CONTROL`.
  - CONTROL bit indices.
- Sub-module `cnt_prescaler` (PRE_W): counter with clear, enable, terminal-compare input and `tick` output.
- The FSM, registers and IRQ logic live in the top module.
- The test bench instantiates a behavioural WIDTH-bit chain model (AO2A + FD1A + XOR per bit, carry-chained) against `cnt_q`.

## Test plan
- Reset mid-RUN (RELOAD = 0xFFF0, PRESCALE = 3, RESET pulsed at cycle 10) -> all outputs return to reset values the same cycle, and no `ld` or `enab` follows.
- One-shot (RELOAD = 0xFFFC, PRESCALE = 0, IRQEN = 1, START) -> one `ld` pulse, 4 `enab` pulses, `irq` = 1 one edge after TC, `running` = 0, `cnt_q` = 0.
- Periodic (RELOAD = 0xFFFE, PRESCALE = 2) -> TC every 7 cycles, `ld` pulse after each TC, `cnt_q` sequence FFFE, FFFF, 0, FFFE...
- STOP and TC on the same edge -> IDLE, `irq` set, no `ld`.
- `irq_ack` coinciding with a new TC -> `irq` stays 1, and a later ack alone clears it.
- With `CNTR_TIMER_GATE_EN`: `gate` = 0 for 5 cycles mid-RUN -> no `enab`, prescaler frozen, TC delayed by exactly 5 cycles.
